// File: rtl/montgomery_mul_pkg.sv
// Shared NTT arithmetic constants and the signed coefficient type used by the
// Montgomery multiplier and its reduction stage.
package montgomery_mul_pkg;

  localparam int unsigned DATA_WIDTH    = 12;
  localparam int unsigned Q             = 3329;
  // Q^-1 mod 2^DATA_WIDTH: 3329 * 769 = 625 * 4096 + 1
  localparam int unsigned QINV          = 769;
  localparam int unsigned MUL_STAGE_CNT = 3;

  typedef logic signed [DATA_WIDTH:0] coeff_t;

endpackage

// File: rtl/montgomery_mul_reduce.sv
// Two-stage Montgomery reduction: given t < Q*2^DATA_WIDTH returns the signed
// residue t * 2^-DATA_WIDTH mod Q in (-Q, Q). Reused by other NTT reduction paths.
module montgomery_mul_reduce #(
  parameter int unsigned DATA_WIDTH = montgomery_mul_pkg::DATA_WIDTH,
  parameter int unsigned Q          = montgomery_mul_pkg::Q,
  parameter int unsigned QINV       = montgomery_mul_pkg::QINV
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [2*DATA_WIDTH-1:0]      t_i,
  output logic signed [DATA_WIDTH:0]   c_o
);
  import montgomery_mul_pkg::*;

  localparam int unsigned TW = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] QW    = DATA_WIDTH'(Q);
  localparam logic [DATA_WIDTH-1:0] QInvW = DATA_WIDTH'(QINV);

  logic [DATA_WIDTH-1:0]      m_d, m_q;
  logic [TW-1:0]              t_d, t_q;
  logic [TW-1:0]              m_prod;
  logic [TW-1:0]              mq;
  logic signed [TW+1:0]       d;
  logic signed [DATA_WIDTH:0] c_d, c_q;

  // Stage 2: m = t * Q^-1 mod R; only the low DATA_WIDTH bits of the product matter.
  always_comb begin
    m_prod = TW'(t_i[DATA_WIDTH-1:0]) * TW'(QInvW);
    m_d    = m_prod[DATA_WIDTH-1:0];
    t_d    = t_i;
  end

  // Stage 3: t - m*Q is an exact multiple of R, so dropping the low bits divides exactly.
  always_comb begin
    mq  = TW'(m_q) * TW'(QW);
    d   = signed'({2'b00, t_q}) - signed'({2'b00, mq});
    c_d = d[TW:DATA_WIDTH];
  end

  logic unused_bits;
  assign unused_bits = ^{d[DATA_WIDTH-1:0], d[TW+1], m_prod[TW-1:DATA_WIDTH]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_q <= '0;
      t_q <= '0;
      c_q <= '0;
    end else begin
      m_q <= m_d;
      t_q <= t_d;
      c_q <= c_d;
    end
  end

  assign c_o = c_q;

endmodule

// File: rtl/montgomery_mul.sv
// Fully pipelined Montgomery multiplier: c == a*b*2^-DATA_WIDTH (mod Q), signed
// result in (-Q, Q), one operand pair per clock, MUL_STAGE_CNT cycles of latency.
module montgomery_mul #(
  parameter int unsigned DATA_WIDTH    = montgomery_mul_pkg::DATA_WIDTH,
  parameter int unsigned Q             = montgomery_mul_pkg::Q,
  parameter int unsigned QINV          = montgomery_mul_pkg::QINV,
  parameter int unsigned MUL_STAGE_CNT = montgomery_mul_pkg::MUL_STAGE_CNT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      a,
  input  logic [DATA_WIDTH-1:0]      b,
  output logic signed [DATA_WIDTH:0] c
);
  import montgomery_mul_pkg::*;

  localparam int unsigned TW = 2 * DATA_WIDTH;

  logic [TW-1:0]              t_d, t_q;
  logic signed [DATA_WIDTH:0] red_c;

  // Stage 1: full-width product, at most Q^2 < 2^TW.
  always_comb begin
    t_d = TW'(a) * TW'(b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q <= '0;
    end else begin
      t_q <= t_d;
    end
  end

  montgomery_mul_reduce #(
    .DATA_WIDTH (DATA_WIDTH),
    .Q          (Q),
    .QINV       (QINV)
  ) u_reduce (
    .clk_i (clk),
    .rst_i (rst),
    .t_i   (t_q),
    .c_o   (red_c)
  );

  // Deeper latency targets get plain delay registers on the output.
  if (MUL_STAGE_CNT > 3) begin : g_pad
    localparam int unsigned PadCnt = MUL_STAGE_CNT - 3;

    logic signed [DATA_WIDTH:0] pad_d [PadCnt];
    logic signed [DATA_WIDTH:0] pad_q [PadCnt];

    always_comb begin
      pad_d[0] = red_c;
      for (int unsigned i = 1; i < PadCnt; i++) begin
        pad_d[i] = pad_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < PadCnt; i++) begin
          pad_q[i] <= '0;
        end
      end else begin
        for (int unsigned i = 0; i < PadCnt; i++) begin
          pad_q[i] <= pad_d[i];
        end
      end
    end

    assign c = pad_q[PadCnt-1];
  end else begin : g_nopad
    assign c = red_c;
  end

endmodule

// File: tb/tb_montgomery_mul.sv
// Scoreboard bench for montgomery_mul: the driver queues expectations per issued
// operand pair, a monitor pops and checks each one when its result is due.
module tb_montgomery_mul;
  import montgomery_mul_pkg::*;

  localparam int QI  = 3329;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] a, b;
  coeff_t      c;

  montgomery_mul dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    bit exact;
    int exp;
    int av;
    int bv;
  } item_t;

  item_t sb[$];
  int    cyc    = 0;
  int    n_pass = 0;
  int    n_chk  = 0;
  int    cmin   = 0;
  int    cmax   = 0;
  bit    seen   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mod_q(int x);
    int r;
    r = x % QI;
    if (r < 0) r += QI;
    return r;
  endfunction

  task automatic check(string name, bit ok, int act, int req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: compare every result that falls due on this cycle.
  initial begin
    item_t it;
    int    cv;
    int    gold;
    int    r;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        it = sb.pop_front();
        cv = int'(c);
        if (it.due != cyc) begin
          check("late_result", 1'b0, it.due, cyc);
        end else if (it.exact) begin
          check($sformatf("exact a=%0d b=%0d cyc=%0d", it.av, it.bv, cyc),
                !$isunknown(c) && cv == it.exp, cv, it.exp);
        end else begin
          gold = (it.av * it.bv) % QI;
          r    = mod_q(4096 * cv);
          check($sformatf("modq a=%0d b=%0d (4096*c mod Q)", it.av, it.bv),
                !$isunknown(c) && r == gold, r, gold);
          if (!seen || cv < cmin) cmin = cv;
          if (!seen || cv > cmax) cmax = cv;
          seen = 1'b1;
        end
      end
    end
  end

  task automatic drive(int av, int bv, bit ex, int exp);
    a = 12'(av);
    b = 12'(bv);
    sb.push_back('{cyc + LAT, ex, exp, av, bv});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vals[$];
    int cnt;

    rst = 1'b1;
    a   = '0;
    b   = '0;
    sb.push_back('{1, 1'b1, 0, 0, 0});
    sb.push_back('{2, 1'b1, 0, 0, 0});
    drive(0, 0, 1'b1, 0);
    drive(0, 0, 1'b1, 0);
    rst = 1'b0;
    repeat (4) drive(0, 0, 1'b1, 0);

    // Directed vectors, back to back.
    drive(1, 1, 1'b1, -625);
    drive(3328, 3328, 1'b1, 2704);
    drive(3329, 3329, 1'b1, 0);
    drive(0, 1234, 1'b1, 0);
    drive(1234, 0, 1'b1, 0);
    drive(2, 1, 1'b1, -1250);
    drive(3329, 1, 1'b1, 0);

    // Subsampled sweep including both ends of the operand range.
    vals = '{0, 1, 2};
    for (int k = 97; k < 3327; k += 97) vals.push_back(k);
    vals.push_back(3327);
    vals.push_back(3328);
    vals.push_back(3329);

    cnt = 0;
    foreach (vals[i]) begin
      foreach (vals[j]) begin
        if (cnt == 700) begin
          // One-cycle reset: the two in-flight results and this pair read 0.
          rst = 1'b1;
          foreach (sb[n]) begin
            if (sb[n].due == cyc + 1 || sb[n].due == cyc + 2) begin
              sb[n].exact = 1'b1;
              sb[n].exp   = 0;
            end
          end
          drive(vals[i], vals[j], 1'b1, 0);
          rst = 1'b0;
        end else begin
          drive(vals[i], vals[j], 1'b0, 0);
        end
        cnt++;
      end
    end

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
    #3;
    check("drain_pending", sb.size() == 0, sb.size(), 0);
    check("range_min", seen && cmin >= -3328, cmin, -3328);
    check("range_max", seen && cmax <= 2705, cmax, 2705);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
